// File: rtl/serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl_if
// Description : Handshake and operand/result bundle for serial_adder_ctrl.
//               master drives start/a/b/cin and observes busy/done/sum/cout
//               (and ovf when SERIAL_ADDER_OVF_EN is defined); slave is the
//               adder controller.
// Ports       : start, a[WIDTH], b[WIDTH], cin   (master -> slave)
//               busy, done, sum[WIDTH], cout, ovf (slave -> master)
// Config      : SERIAL_ADDER_OVF_EN adds the ovf signal.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (output start, a, b, cin,
                    input  busy, done, sum, cout, ovf);
    modport slave  (input  start, a, b, cin,
                    output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin,
                    input  busy, done, sum, cout);
    modport slave  (input  start, a, b, cin,
                    output busy, done, sum, cout);
`endif
endinterface
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl (with leaf FullAdder1bit_Behavioral)
// Description : Bit-serial adder. One 1-bit full adder is stepped LSB first,
//               one bit per clock, over two WIDTH-bit operands. The result
//               appears WIDTH cycles after the accepting edge with a
//               one-cycle done pulse; sum/cout/ovf only change at completion.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - serial_adder_ctrl_if.slave (start/a/b/cin in,
//                       busy/done/sum/cout[/ovf] out)
// Parameters  : WIDTH - operand/result width, 2..32; must match the
//               interface instance.
// Config      : SERIAL_ADDER_OVF_EN - adds the signed overflow register.
// Revision    : 1.0 - initial release
// ============================================================================

module FullAdder1bit_Behavioral (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_adder_ctrl_if.slave  bus
);
    localparam int             CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_load;
    logic               w_last;

    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    // Only WIDTH-1 partial sums need storing; the final bit arrives straight
    // from the adder on the completion edge.
    logic [WIDTH-2:0]   r_res_sh;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic               w_fa_sum;
    logic               w_fa_cout;
    logic [WIDTH-1:0]   w_res_next;

    FullAdder1bit_Behavioral u_fa (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_carry),
        .sum  (w_fa_sum),
        .cout (w_fa_cout)
    );

    assign w_res_next = {w_fa_sum, r_res_sh};
    assign w_last     = (r_state == S_RUN) && (r_cnt == C_LAST);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next state / load decode ----------------
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_load       = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == C_LAST) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                // DONE doubles as an accept slot so back-to-back requests
                // cost only one extra cycle.
                if (bus.start) begin
                    w_load       = 1'b1;
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else begin
            if (w_load) begin
                r_a_sh  <= bus.a;
                r_b_sh  <= bus.b;
                r_carry <= bus.cin;
                r_cnt   <= '0;
            end else if (r_state == S_RUN) begin
                r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                r_res_sh <= w_res_next[WIDTH-1:1];
                r_carry  <= w_fa_cout;
                // Hold on the last bit so the counter never wraps.
                if (!w_last) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            if (w_last) begin
                r_sum  <= w_res_next;
                r_cout <= w_fa_cout;
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= r_carry ^ w_fa_cout;
        end
    end

    assign bus.ovf = r_ovf;
`endif

    assign bus.busy = (r_state == S_RUN);
    assign bus.done = (r_state == S_DONE);
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder_ctrl
// Description : Self-checking bench for serial_adder_ctrl (WIDTH=8). Directed
//               scenarios plus random operands, compared against an
//               arithmetic reference model.
// Config      : SERIAL_ADDER_OVF_EN enables ovf checking.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
        int          u;
        int          s;
        logic [W+1:0] r;
        u = int'(a) + int'(b) + int'(cin);
        s = int'($signed(a)) + int'($signed(b)) + int'(cin);
        r[W-1:0] = W'(u % (1 << W));
        r[W]     = (u >= (1 << W));
        r[W+1]   = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
        return r;
    endfunction

    task automatic check_result(input string tag, input logic [W+1:0] exp);
        chk({tag, ".sum"}, bus.sum, exp[W-1:0]);
        chk({tag, ".cout"}, bus.cout, exp[W]);
`ifdef SERIAL_ADDER_OVF_EN
        chk({tag, ".ovf"}, bus.ovf, exp[W+1]);
`endif
    endtask

    // Entered just after a rising edge with the DUT in IDLE or DONE.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input bit poke);
        logic [W+1:0] exp;
        logic [W-1:0] prev_sum;
        int           lat;
        int           nbusy;
        bit           partial;
        exp      = model(a, b, cin);
        prev_sum = bus.sum;
        lat      = 0;
        nbusy    = 0;
        partial  = 0;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.cin   = 1'($urandom);
        if (bus.busy) nbusy++;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (poke) begin
                if (k == 2) begin
                    bus.start = 1'b1;
                    bus.a     = 8'hAA;
                end else if (k == 3) begin
                    bus.start = 1'b0;
                end
            end
            if (bus.done) begin
                lat = k;
                break;
            end
            if (bus.busy) nbusy++;
            if (bus.sum !== prev_sum) partial = 1;
        end
        chk({tag, ".latency"}, lat, W);
        chk({tag, ".busy_cycles"}, nbusy, W);
        chk({tag, ".no_partial"}, partial, 0);
        check_result(tag, exp);
        @(posedge clk); #1;
        chk({tag, ".done_1cyc"}, bus.done, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bit           changed;
        bit           seen_done;
        int           lat;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;

        // ---- reset then idle ----
        #2 rst_n = 1'b0;
        #1;
        chk("rst.busy", bus.busy, 1'b0);
        chk("rst.done", bus.done, 1'b0);
        chk("rst.sum",  bus.sum,  '0);
        chk("rst.cout", bus.cout, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst.ovf",  bus.ovf,  1'b0);
`endif
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        changed = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.busy || bus.done || bus.sum !== '0 || bus.cout) changed = 1;
        end
        chk("idle.stable", changed, 0);

        // ---- basic and carry chain ----
        do_op("basic",  8'h0F, 8'h01, 1'b0, 0);
        do_op("carry",  8'hFF, 8'h01, 1'b0, 0);
        do_op("ovf",    8'h7F, 8'h01, 1'b0, 0);
        do_op("allone", 8'hFF, 8'hFF, 1'b1, 0);

        // ---- start during RUN is ignored ----
        do_op("midstart", 8'h12, 8'h34, 1'b0, 1);

        // ---- back-to-back with start held high ----
        bus.start = 1'b1;
        bus.a     = 8'h01;
        bus.b     = 8'h02;
        bus.cin   = 1'b0;
        @(posedge clk); #1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        chk("b2b.first_lat", lat, W);
        check_result("b2b.first", model(8'h01, 8'h02, 1'b0));
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        chk("b2b.spacing", lat, W + 1);
        check_result("b2b.second", model(8'h01, 8'h02, 1'b0));
        bus.start = 1'b0;
        @(posedge clk); #1;

        // ---- reset in the middle of RUN ----
        bus.start = 1'b1;
        bus.a     = 8'hC3;
        bus.b     = 8'h5A;
        bus.cin   = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.busy", bus.busy, 1'b0);
        chk("abort.done", bus.done, 1'b0);
        chk("abort.sum",  bus.sum,  '0);
        chk("abort.cout", bus.cout, 1'b0);
        seen_done = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.done) seen_done = 1;
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.done) seen_done = 1;
        end
        chk("abort.no_done", seen_done, 0);
        do_op("after_abort", 8'h05, 8'h03, 1'b0, 0);

        // ---- random operands ----
        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            do_op("rand", ra, rb, 1'($urandom), (i % 5) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
